sdram_burst_arbiter: RTL and testbench
======================================

// Module: sdram_burst_arbiter
// PURPOSE
//  Shares the single SDRAM burst-read port between three requesters: 0 = video scanout, 1 = CPU refill, 2 = DMA/blitter.
//  Sits between the requesters and the SDRAM controller, in the clk_sdram domain.
//  Captures single-cycle request pulses and forwards one burst at a time.
//  Routes returned data to the owning requester.
//  Port 0 has fixed top priority (line deadline); ports 1/2 share the rest round-robin.
// PARAMETERS
//  TIMEOUT_CYCLES  4096  BUSY-state watchdog limit (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk_sdram        in   1   SDRAM clock (133 MHz); sole clock
//  reset            in   1   synchronous, active-high reset
//  req_rd           in   3   per-port 1-cycle burst request pulse, bit i = port i
//  req_addr         in   75  per-port 25-bit word address, port i at [25i+24:25i]
//  req_len          in   33  per-port 11-bit length (16-bit words), port i at [11i+10:11i]
//  req_32bit        in   3   per-port 32-bit burst mode
//  req_data         out  32  burst_data broadcast to all ports (combinational pass-through)
//  req_data_valid   out  3   burst_data_valid gated to owner only
//  req_data_done    out  3   burst_data_done gated to owner only
//  burst_rd         out  1   1-cycle request to SDRAM controller
//  burst_addr       out  25  latched address of granted port
//  burst_len        out  11  latched length of granted port
//  burst_32bit      out  1   latched mode of granted port
//  burst_data       in   32  SDRAM read data
//  burst_data_valid in   1   SDRAM data strobe
//  burst_data_done  in   1   SDRAM end-of-burst strobe
//  owner            out  2   current owner, 0-2; 3 = none
//  overflow         out  3   sticky per-port flag: request dropped while already pending
//  timeout_err      out  1   sticky watchdog flag (0 when ARB_TIMEOUT_EN is undefined)
// BEHAVIOUR
//  Reset:
//   - All outputs registered to 0, except owner = 3; state = IDLE.
//   - pending, overflow, timeout_err and round-robin pointer (rr = port 1 next) cleared.
//  Capture:
//   - req_rd[i] sets pending[i] and latches addr/len/32bit[i].
//   - If pending[i] is already set, the new request is dropped and overflow[i] set; the latched values are kept.
//   - A new pulse in the same cycle that pending[i] is cleared by a grant is captured: set wins.
//  FSM states:
//   - IDLE: if any pending, grant port 0 first, else rr port; else port 1 or 2 alone.
//     On grant: clear pending[g], load burst_* from latch, burst_rd = 1 for one cycle, owner = g, go to BUSY.
//     rr toggles only when port 1 or 2 is granted.
//   - BUSY: req_data_valid[owner] = burst_data_valid; req_data_done[owner] = burst_data_done.
//     On burst_data_done, go to IDLE and set owner = 3 on the next edge. Valid and done in the same cycle are both routed.
//  No preemption: port 0 waits for the current burst to finish.
//  Latency:
//   - req_rd pulse at cycle t (arbiter IDLE, no competitor) -> burst_rd high at t+2.
//   - After done, the next grant's burst_rd is at the earliest done+2.
//  burst_data_valid or burst_data_done in IDLE is ignored; no port sees it.
//  burst_addr/len/32bit hold their value after burst_rd until the next grant.
//  Reset asserted mid-burst: immediate return to IDLE; pending requests are lost.
//   Requesters must re-issue.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - 12-bit counter runs in BUSY and clears on entry.
//   - When it reaches TIMEOUT_CYCLES without done: pulse req_data_done[owner] once, set timeout_err, go to IDLE.
//  ARB_TIMEOUT_EN undefined: no counter; BUSY waits forever; timeout_err tied 0.
// TESTING
//  1. Single request: req_rd[0], addr 0x0001400, len 320 at t -> burst_rd at t+2 with the same addr/len.
//     owner = 0; 160 valids reach req_data_valid[0] only.
//  2. Priority: req_rd[1] and [0] at the same cycle -> port 0 granted first, port 1 at done+2.
//  3. Round-robin: ports 1 and 2 held continuously pending for 4 grants -> grant order 1,2,1,2.
//  4. Overflow: second req_rd[2] while pending[2] is set -> overflow = 3'b100.
//     The original addr is issued and only one burst runs.
//  5. Reset mid-burst after 10 valids -> next cycle owner = 3, burst_rd = 0.
//     Subsequent burst_data_valid pulses are not routed.
//  6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 64, done withheld:
//     req_data_done[owner] pulses 64 cycles after the grant, timeout_err = 1, arbiter back to IDLE.

Source files
------------

// File: rtl/sdram_burst_arbiter_if.sv
// sdram_burst_arbiter_if
//   Bundles every signal of the SDRAM burst-read arbiter except the clock
//   and reset. The slave modport is the arbiter's own view. The master
//   modport is the surrounding system: the three requesters and the SDRAM
//   controller.
interface sdram_burst_arbiter_if;
    // Requester side
    logic [2:0]  req_rd;
    logic [74:0] req_addr;
    logic [32:0] req_len;
    logic [2:0]  req_32bit;
    logic [31:0] req_data;
    logic [2:0]  req_data_valid;
    logic [2:0]  req_data_done;

    // SDRAM controller side
    logic        burst_rd;
    logic [24:0] burst_addr;
    logic [10:0] burst_len;
    logic        burst_32bit;
    logic [31:0] burst_data;
    logic        burst_data_valid;
    logic        burst_data_done;

    // Status
    logic [1:0]  owner;
    logic [2:0]  overflow;
    logic        timeout_err;

    modport slave (
        input  req_rd, req_addr, req_len, req_32bit,
        output req_data, req_data_valid, req_data_done,
        output burst_rd, burst_addr, burst_len, burst_32bit,
        input  burst_data, burst_data_valid, burst_data_done,
        output owner, overflow, timeout_err
    );

    modport master (
        output req_rd, req_addr, req_len, req_32bit,
        input  req_data, req_data_valid, req_data_done,
        input  burst_rd, burst_addr, burst_len, burst_32bit,
        output burst_data, burst_data_valid, burst_data_done,
        input  owner, overflow, timeout_err
    );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter
//   Shares the single SDRAM burst-read port between three requesters:
//   port 0 = video scanout, port 1 = CPU refill, port 2 = DMA/blitter.
//   Single-cycle request pulses are captured into per-port pending latches.
//   One burst is forwarded at a time, and returned data is routed to the
//   port that owns the current burst.
//
//   Priority: port 0 always wins (scanout line deadline). Ports 1 and 2
//   share the remaining bandwidth round-robin. A running burst is never
//   preempted.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When defined, a BUSY-state watchdog ends a burst whose done strobe
//     never arrives. It fakes a done pulse to the owner and sets the
//     sticky timeout_err flag.
//     When undefined, BUSY waits forever for done and timeout_err is tied
//     to 0.
//
//   Runs entirely in the clk_sdram domain.
//   Reset is synchronous and active-high.
module sdram_burst_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_sdram,
    input  logic                  reset,
    sdram_burst_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    // Captured requests
    logic [2:0]  pending;
    logic [24:0] lat_addr [3];
    logic [10:0] lat_len  [3];
    logic [2:0]  lat_32bit;

    // Round-robin pointer between ports 1 and 2: 0 -> port 1 next, 1 -> port 2 next
    logic        rr;

    // Registered outputs
    logic        burst_rd_q;
    logic [24:0] burst_addr_q;
    logic [10:0] burst_len_q;
    logic        burst_32bit_q;
    logic [1:0]  owner_q;
    logic [2:0]  overflow_q;

    // Grant decision for the current cycle
    logic        grant_en;
    logic [1:0]  grant_port;
    logic [2:0]  grant_clear;

    // Watchdog expiry (constant 0 without the watchdog)
    logic        timeout_hit;

    // Routing of the current owner as a one-hot mask
    logic [2:0]  owner_onehot;

    // State register
    always_ff @(posedge clk_sdram) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and grant selection: port 0 first, then the round-robin
    // choice when ports 1 and 2 both wait, else whichever of 1/2 waits
    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        grant_port = 2'd0;
        case (state)
            IDLE: begin
                if (pending[0]) begin
                    grant_en   = 1'b1;
                    grant_port = 2'd0;
                end else if (pending[1] && pending[2]) begin
                    grant_en   = 1'b1;
                    grant_port = rr ? 2'd2 : 2'd1;
                end else if (pending[1]) begin
                    grant_en   = 1'b1;
                    grant_port = 2'd1;
                end else if (pending[2]) begin
                    grant_en   = 1'b1;
                    grant_port = 2'd2;
                end
                if (grant_en) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (bus.burst_data_done || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign grant_clear = grant_en ? (3'b001 << grant_port) : 3'b000;

    // Output routing: valid/done strobes reach only the owning port, and
    // only while a burst is running; strobes seen in IDLE are dropped
    always_comb begin
        owner_onehot       = 3'b000;
        bus.req_data_valid = 3'b000;
        bus.req_data_done  = 3'b000;
        if (state == BUSY) begin
            case (owner_q)
                2'd0:    owner_onehot = 3'b001;
                2'd1:    owner_onehot = 3'b010;
                2'd2:    owner_onehot = 3'b100;
                default: owner_onehot = 3'b000;
            endcase
            if (bus.burst_data_valid) begin
                bus.req_data_valid = owner_onehot;
            end
            if (bus.burst_data_done || timeout_hit) begin
                bus.req_data_done = owner_onehot;
            end
        end
    end

    // Request capture, grant bookkeeping and burst descriptor registers.
    // A pulse in the same cycle that pending is cleared by a grant is
    // captured. The old latch contents are loaded into burst_* on this
    // same edge, so nothing is lost.
    always_ff @(posedge clk_sdram) begin
        if (reset) begin
            pending       <= 3'b000;
            lat_32bit     <= 3'b000;
            overflow_q    <= 3'b000;
            rr            <= 1'b0;
            burst_rd_q    <= 1'b0;
            burst_addr_q  <= 25'd0;
            burst_len_q   <= 11'd0;
            burst_32bit_q <= 1'b0;
            owner_q       <= 2'd3;
            for (int i = 0; i < 3; i++) begin
                lat_addr[i] <= 25'd0;
                lat_len[i]  <= 11'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (bus.req_rd[i]) begin
                    if (pending[i] && !grant_clear[i]) begin
                        overflow_q[i] <= 1'b1;
                    end else begin
                        lat_addr[i]  <= bus.req_addr[25*i +: 25];
                        lat_len[i]   <= bus.req_len[11*i +: 11];
                        lat_32bit[i] <= bus.req_32bit[i];
                    end
                end
            end

            pending    <= (pending & ~grant_clear) | bus.req_rd;
            burst_rd_q <= grant_en;

            if (grant_en) begin
                burst_addr_q  <= lat_addr[grant_port];
                burst_len_q   <= lat_len[grant_port];
                burst_32bit_q <= lat_32bit[grant_port];
                owner_q       <= grant_port;
                if (grant_port != 2'd0) begin
                    rr <= ~rr;
                end
            end else if ((state == BUSY) && (state_next == IDLE)) begin
                owner_q <= 2'd3;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    // The counter reads 0 in the first BUSY cycle, which is the burst_rd
    // cycle. It expires at TIMEOUT_CYCLES-1. That is TIMEOUT_CYCLES cycles
    // after the IDLE cycle in which the grant was decided.
    localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT_CYCLES - 1);

    logic [11:0] busy_count;
    logic        timeout_err_q;

    assign timeout_hit = (state == BUSY) && !bus.burst_data_done &&
                         (busy_count == TIMEOUT_LAST);

    // Watchdog counter, cleared on every grant, and sticky error flag
    always_ff @(posedge clk_sdram) begin
        if (reset) begin
            busy_count    <= 12'd0;
            timeout_err_q <= 1'b0;
        end else begin
            if (grant_en) begin
                busy_count <= 12'd0;
            end else if (state == BUSY) begin
                busy_count <= busy_count + 12'd1;
            end
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
    assign bus.timeout_err    = 1'b0;
`endif

    assign bus.req_data    = bus.burst_data;
    assign bus.burst_rd    = burst_rd_q;
    assign bus.burst_addr  = burst_addr_q;
    assign bus.burst_len   = burst_len_q;
    assign bus.burst_32bit = burst_32bit_q;
    assign bus.owner       = owner_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// tb_sdram_burst_arbiter
//   Directed bench for sdram_burst_arbiter.
//   Each request driven pushes the burst descriptor the arbiter should
//   issue. Descriptors are pushed in the order the grants are expected.
//   Each burst_rd seen pops one descriptor and compares it with the
//   DUT outputs.
//   Inputs change 1 time unit after the rising edge. Combinational outputs
//   are sampled on the falling edge; registered outputs may be sampled
//   right after the rising edge.
module tb_sdram_burst_arbiter;

    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [1:0]  port;
        logic [24:0] addr;
        logic [10:0] len;
        logic        b32;
    } burst_exp_t;

    burst_exp_t  sb[$];
    logic [24:0] p_addr [3];
    logic [10:0] p_len  [3];
    logic [2:0]  p_32;

    sdram_burst_arbiter_if bus();

    sdram_burst_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_sdram (clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Hard stop in case a wait logic bug slips through
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Pulse req_rd for the ports in mask for one cycle with the current p_* fields
    task automatic applyStimulus(input logic [2:0] mask);
        for (int i = 0; i < 3; i++) begin
            bus.req_addr[25*i +: 25] = p_addr[i];
            bus.req_len[11*i +: 11]  = p_len[i];
        end
        bus.req_32bit = p_32;
        bus.req_rd    = mask;
        step();
        bus.req_rd    = 3'b000;
    endtask

    task automatic expectBurst(input int port);
        burst_exp_t e;
        e.port = 2'(port);
        e.addr = p_addr[port];
        e.len  = p_len[port];
        e.b32  = p_32[port];
        sb.push_back(e);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Called one cycle after the reference cycle (request or done);
    // exp_lat counts cycles from that reference to burst_rd
    task automatic waitBurst(input int exp_lat);
        int         lat;
        bit         seen;
        burst_exp_t e;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            @(negedge clk);
            if (bus.burst_rd === 1'b1) begin
                seen = 1'b1;
            end else begin
                step();
                lat++;
            end
        end
        checkOutput("grant_latency", lat, exp_lat);
        if (seen) begin
            checkOutput("sb_has_entry", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("grant_owner", bus.owner, e.port);
                checkOutput("burst_addr", bus.burst_addr, e.addr);
                checkOutput("burst_len", bus.burst_len, e.len);
                checkOutput("burst_32bit", bus.burst_32bit, e.b32);
            end
            step();
        end
    endtask

    // mode 0: valids only; 1: done after the last valid; 2: done with the last valid
    task automatic serveBurst(input int port, input int n, input int mode);
        logic [31:0] d;
        logic [2:0]  own;
        own = 3'b001 << port;
        for (int k = 0; k < n; k++) begin
            d = $urandom;
            bus.burst_data       = d;
            bus.burst_data_valid = 1'b1;
            bus.burst_data_done  = (mode == 2) && (k == n - 1);
            @(negedge clk);
            if (k == 0) checkOutput("burst_rd_one_cycle", bus.burst_rd, 0);
            checkOutput("valid_route", bus.req_data_valid, own);
            checkOutput("data_pass", bus.req_data, d);
            if ((mode == 2) && (k == n - 1)) checkOutput("done_with_valid", bus.req_data_done, own);
            step();
        end
        bus.burst_data_valid = 1'b0;
        bus.burst_data_done  = 1'b0;
        if (mode == 1) begin
            bus.burst_data_done = 1'b1;
            @(negedge clk);
            checkOutput("done_route", bus.req_data_done, own);
            checkOutput("no_valid_on_done", bus.req_data_valid, 0);
            step();
            bus.burst_data_done = 1'b0;
        end
        if (mode != 0) checkOutput("owner_released", bus.owner, 2'd3);
    endtask

    task automatic expectNoBurst(input int n);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus.burst_rd === 1'b1) seen++;
            step();
        end
        checkOutput("no_extra_burst", seen, 0);
    endtask

    initial begin
        bus.req_rd           = 3'b000;
        bus.req_addr         = '0;
        bus.req_len          = '0;
        bus.req_32bit        = 3'b000;
        bus.burst_data       = 32'd0;
        bus.burst_data_valid = 1'b0;
        bus.burst_data_done  = 1'b0;
        p_32                 = 3'b000;
        for (int i = 0; i < 3; i++) begin
            p_addr[i] = 25'd0;
            p_len[i]  = 11'd0;
        end
        reset = 1'b1;
        step();
        step();

        // Reset state
        checkOutput("rst_owner", bus.owner, 2'd3);
        checkOutput("rst_burst_rd", bus.burst_rd, 0);
        checkOutput("rst_burst_addr", bus.burst_addr, 0);
        checkOutput("rst_burst_len", bus.burst_len, 0);
        checkOutput("rst_overflow", bus.overflow, 0);
        checkOutput("rst_timeout_err", bus.timeout_err, 0);
        reset = 1'b0;
        step();

        // Single request on port 0, 32-bit mode: 320 words = 160 beats
        $display("[TB] single request");
        p_addr[0] = 25'h0001400;
        p_len[0]  = 11'd320;
        p_32      = 3'b001;
        applyStimulus(3'b001);
        expectBurst(0);
        waitBurst(2);
        serveBurst(0, 160, 1);
        checkOutput("hold_addr", bus.burst_addr, 25'h0001400);
        checkOutput("hold_len", bus.burst_len, 11'd320);

        // Ports 0 and 1 requested together: port 0 first, port 1 at done+2
        $display("[TB] priority");
        p_addr[0] = 25'h0ABCDE0;
        p_len[0]  = 11'd16;
        p_addr[1] = 25'h1234560;
        p_len[1]  = 11'd8;
        p_32      = 3'b010;
        applyStimulus(3'b011);
        expectBurst(0);
        expectBurst(1);
        waitBurst(2);
        serveBurst(0, 4, 1);
        waitBurst(2);
        serveBurst(1, 4, 2);

        // Ports 1 and 2 kept pending: grant order 1,2,1,2
        $display("[TB] round robin");
        applyReset();
        p_32      = 3'b000;
        p_addr[1] = 25'h0100010;
        p_len[1]  = 11'd5;
        p_addr[2] = 25'h0200020;
        p_len[2]  = 11'd6;
        applyStimulus(3'b110);
        expectBurst(1);
        expectBurst(2);
        waitBurst(2);
        p_addr[1] = 25'h0100030;
        applyStimulus(3'b010);
        expectBurst(1);
        serveBurst(1, 3, 1);
        waitBurst(2);
        p_addr[2] = 25'h0200040;
        applyStimulus(3'b100);
        expectBurst(2);
        serveBurst(2, 3, 1);
        waitBurst(2);
        serveBurst(1, 3, 1);
        waitBurst(2);
        serveBurst(2, 3, 1);

        // Second port-2 request while pending is dropped and flagged
        $display("[TB] overflow");
        applyReset();
        p_addr[0] = 25'h0000C00;
        p_len[0]  = 11'd4;
        applyStimulus(3'b001);
        expectBurst(0);
        waitBurst(2);
        p_addr[2] = 25'h1B00B10;
        p_len[2]  = 11'd7;
        p_32      = 3'b100;
        applyStimulus(3'b100);
        expectBurst(2);
        checkOutput("overflow_clear", bus.overflow, 0);
        p_addr[2] = 25'h1B00B20;
        p_len[2]  = 11'd9;
        applyStimulus(3'b100);
        checkOutput("overflow_set", bus.overflow, 3'b100);
        serveBurst(0, 3, 1);
        waitBurst(2);
        serveBurst(2, 4, 1);
        expectNoBurst(8);
        checkOutput("sb_empty_ovf", sb.size(), 0);
        checkOutput("overflow_sticky", bus.overflow, 3'b100);

        // Reset in the middle of a burst; a queued port-2 request is lost
        $display("[TB] reset mid-burst");
        applyReset();
        p_32      = 3'b000;
        p_addr[1] = 25'h0777700;
        p_len[1]  = 11'd40;
        applyStimulus(3'b010);
        expectBurst(1);
        waitBurst(2);
        p_addr[2] = 25'h0888800;
        applyStimulus(3'b100);
        serveBurst(1, 10, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("rst_mid_owner", bus.owner, 2'd3);
        checkOutput("rst_mid_burst_rd", bus.burst_rd, 0);
        for (int k = 0; k < 4; k++) begin
            bus.burst_data_valid = 1'b1;
            bus.burst_data_done  = (k == 3);
            @(negedge clk);
            checkOutput("idle_valid_dropped", bus.req_data_valid, 0);
            checkOutput("idle_done_dropped", bus.req_data_done, 0);
            step();
        end
        bus.burst_data_valid = 1'b0;
        bus.burst_data_done  = 1'b0;
        expectNoBurst(6);
        checkOutput("sb_empty_rst", sb.size(), 0);

`ifdef ARB_TIMEOUT_EN
        // Done withheld: the watchdog ends the burst
        $display("[TB] timeout");
        applyReset();
        p_addr[0] = 25'h0012340;
        p_len[0]  = 11'd100;
        applyStimulus(3'b001);
        expectBurst(0);
        waitBurst(2);
        begin
            int   k;
            bit   hit;
            logic [2:0] mask;
            k    = 1;
            hit  = 1'b0;
            mask = 3'b000;
            while (!hit && k < 200) begin
                @(negedge clk);
                if (bus.req_data_done != 3'b000) begin
                    hit  = 1'b1;
                    mask = bus.req_data_done;
                end else begin
                    step();
                    k++;
                end
            end
            checkOutput("timeout_cycle", k, TIMEOUT - 1);
            checkOutput("timeout_done_port", mask, 3'b001);
            step();
        end
        checkOutput("timeout_err_set", bus.timeout_err, 1);
        checkOutput("timeout_owner", bus.owner, 2'd3);
        p_addr[1] = 25'h0055550;
        p_len[1]  = 11'd2;
        applyStimulus(3'b010);
        expectBurst(1);
        waitBurst(2);
        serveBurst(1, 2, 1);
`else
        checkOutput("timeout_err_tied", bus.timeout_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
